// File: rtl/dma_copy_engine_pkg.sv
// Shared types for the DMA copy engine: DataBus access/length encodings,
// FSM state encodings and beat step constants.
package dma_copy_engine_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_NONE = 2'd0,
    MEM_ACCESS_R    = 2'd1,
    MEM_ACCESS_W    = 2'd2
  } mem_access_t;

  typedef enum logic [1:0] {
    MEM_LEN_B = 2'd0,
    MEM_LEN_H = 2'd1,
    MEM_LEN_W = 2'd2
  } mem_len_t;

  typedef enum logic [2:0] {
    DMA_ST_IDLE  = 3'd0,
    DMA_ST_RD    = 3'd1,
    DMA_ST_RDATA = 3'd2,
    DMA_ST_WR    = 3'd3,
    DMA_ST_DONE  = 3'd4
  } dma_state_t;

  localparam logic [2:0] DMA_STEP_W = 3'd4;
  localparam logic [2:0] DMA_STEP_H = 3'd2;
  localparam logic [2:0] DMA_STEP_B = 3'd1;

  // Keeps only the right-aligned bytes that belong to an access of length ml.
  function automatic logic [31:0] len_mask(input mem_len_t ml);
    case (ml)
      MEM_LEN_B: len_mask = 32'h0000_00FF;
      MEM_LEN_H: len_mask = 32'h0000_FFFF;
      default:   len_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/dma_copy_engine_if.sv
// DataBus initiator/responder signal bundle shared with CPUCore.
interface dma_copy_engine_if;
  import dma_copy_engine_pkg::*;

  logic [31:0] addr;
  logic [31:0] dataOut;
  mem_access_t accessType;
  mem_len_t    memLen;
  logic [31:0] dataIn;
  logic        ready;

  modport master (
    output addr, dataOut, accessType, memLen,
    input  dataIn, ready
  );

  modport slave (
    input  addr, dataOut, accessType, memLen,
    output dataIn, ready
  );

endinterface

// File: rtl/dma_copy_engine_len_sel.sv
// Picks the widest access that fits in the remaining byte count and its step.
module dma_copy_engine_len_sel
  import dma_copy_engine_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter bit WORD_ONLY = 1'b0
) (
  input  logic [LEN_W-1:0] rem_i,
  output mem_len_t         mem_len_o,
  output logic [2:0]       step_o
);

  always_comb begin
    mem_len_o = MEM_LEN_W;
    step_o    = DMA_STEP_W;
    if (WORD_ONLY) begin
      mem_len_o = MEM_LEN_W;
      step_o    = DMA_STEP_W;
    end else if (rem_i >= LEN_W'(4)) begin
      mem_len_o = MEM_LEN_W;
      step_o    = DMA_STEP_W;
    end else if (rem_i >= LEN_W'(2)) begin
      mem_len_o = MEM_LEN_H;
      step_o    = DMA_STEP_H;
    end else begin
      mem_len_o = MEM_LEN_B;
      step_o    = DMA_STEP_B;
    end
  end

endmodule

// File: rtl/dma_copy_engine.sv
// DataBus copy engine: big-endian read-then-write byte region copy.
// Optional DMA_FILL_EN adds fillMode/fillData for write-only pattern fills.
module dma_copy_engine
  import dma_copy_engine_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter bit WORD_ONLY = 1'b0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [31:0]      srcAddr,
  input  logic [31:0]      dstAddr,
  input  logic [LEN_W-1:0] len,
`ifdef DMA_FILL_EN
  input  logic             fillMode,
  input  logic [31:0]      fillData,
`endif
  output logic             busy,
  output logic             done,
  dma_copy_engine_if.master db
);

  dma_state_t       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      data_q, data_d;

  mem_len_t         mem_len_s;
  logic [2:0]       step_s;
  logic [LEN_W-1:0] step_ext_s;
  logic [LEN_W-1:0] len_eff_s;
  logic             start_fill_s;
  logic             fill_active_s;
  logic [31:0]      wr_data_s;

`ifdef DMA_FILL_EN
  logic             fill_q, fill_d;
  logic [31:0]      fill_data_q, fill_data_d;

  assign start_fill_s  = fillMode;
  assign fill_active_s = fill_q;
`else
  assign start_fill_s  = 1'b0;
  assign fill_active_s = 1'b0;
`endif

  dma_copy_engine_len_sel #(
    .LEN_W     (LEN_W),
    .WORD_ONLY (WORD_ONLY)
  ) u_len_sel (
    .rem_i     (rem_q),
    .mem_len_o (mem_len_s),
    .step_o    (step_s)
  );

  assign step_ext_s = {{(LEN_W-3){1'b0}}, step_s};
  assign len_eff_s  = WORD_ONLY ? {len[LEN_W-1:2], 2'b00} : len;

`ifdef DMA_FILL_EN
  assign wr_data_s = fill_active_s ? (fill_data_q & len_mask(mem_len_s)) : data_q;
`else
  assign wr_data_s = data_q;
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= DMA_ST_IDLE;
      src_q       <= 32'h0000_0000;
      dst_q       <= 32'h0000_0000;
      rem_q       <= '0;
      data_q      <= 32'h0000_0000;
`ifdef DMA_FILL_EN
      fill_q      <= 1'b0;
      fill_data_q <= 32'h0000_0000;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
`ifdef DMA_FILL_EN
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
`endif
    end
  end

  // Step selection never exceeds rem, so the decrement cannot underflow.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    data_d      = data_q;
`ifdef DMA_FILL_EN
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
`endif
    case (state_q)
      DMA_ST_IDLE: begin
        if (start) begin
          src_d = srcAddr;
          dst_d = dstAddr;
          rem_d = len_eff_s;
`ifdef DMA_FILL_EN
          fill_d      = fillMode;
          fill_data_d = fillData;
`endif
          if (len_eff_s == '0) begin
            state_d = DMA_ST_DONE;
          end else if (start_fill_s) begin
            state_d = DMA_ST_WR;
          end else begin
            state_d = DMA_ST_RD;
          end
        end else begin
          state_d = DMA_ST_IDLE;
        end
      end
      DMA_ST_RD: begin
        if (db.ready) begin
          state_d = DMA_ST_RDATA;
        end else begin
          state_d = DMA_ST_RD;
        end
      end
      DMA_ST_RDATA: begin
        data_d  = db.dataIn & len_mask(mem_len_s);
        state_d = DMA_ST_WR;
      end
      DMA_ST_WR: begin
        if (db.ready) begin
          src_d = src_q + {29'h0000_0000, step_s};
          dst_d = dst_q + {29'h0000_0000, step_s};
          rem_d = rem_q - step_ext_s;
          if (rem_d == '0) begin
            state_d = DMA_ST_DONE;
          end else if (fill_active_s) begin
            state_d = DMA_ST_WR;
          end else begin
            state_d = DMA_ST_RD;
          end
        end else begin
          state_d = DMA_ST_WR;
        end
      end
      DMA_ST_DONE: begin
        state_d = DMA_ST_IDLE;
      end
      default: begin
        state_d = DMA_ST_IDLE;
      end
    endcase
  end

  // Bus outputs decode only registered state, so they hold steady under stalls.
  always_comb begin
    db.accessType = MEM_ACCESS_NONE;
    db.addr       = 32'h0000_0000;
    db.dataOut    = 32'h0000_0000;
    db.memLen     = MEM_LEN_W;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      DMA_ST_RD: begin
        db.accessType = MEM_ACCESS_R;
        db.addr       = src_q;
        db.memLen     = mem_len_s;
        busy          = 1'b1;
      end
      DMA_ST_RDATA: begin
        busy = 1'b1;
      end
      DMA_ST_WR: begin
        db.accessType = MEM_ACCESS_W;
        db.addr       = dst_q;
        db.memLen     = mem_len_s;
        db.dataOut    = wr_data_s;
        busy          = 1'b1;
      end
      DMA_ST_DONE: begin
        done = 1'b1;
      end
      DMA_ST_IDLE: begin
        busy = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: a byte-memory responder serves the bus,
// expected beats are queued by the stimulus and popped by a bus monitor.
module tb_dma_copy_engine;
  import dma_copy_engine_pkg::*;

  typedef struct {
    mem_access_t kind;
    logic [31:0] addr;
    mem_len_t    ml;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        res;
  logic        start;
  logic [31:0] srcAddr;
  logic [31:0] dstAddr;
  logic [15:0] len;
  logic        busy;
  logic        done;
`ifdef DMA_FILL_EN
  logic        fillMode;
  logic [31:0] fillData;
`endif

  dma_copy_engine_if db ();

  dma_copy_engine #(.LEN_W(16), .WORD_ONLY(1'b0)) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .srcAddr  (srcAddr),
    .dstAddr  (dstAddr),
    .len      (len),
`ifdef DMA_FILL_EN
    .fillMode (fillMode),
    .fillData (fillData),
`endif
    .busy     (busy),
    .done     (done),
    .db       (db)
  );

  int          total = 0;
  int          bad   = 0;
  beat_t       sbq[$];
  bit   [7:0]  mem [bit [31:0]];
  logic        toggle_en;
  int          cyc;
  int          bc;
  int          idle_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input mem_len_t ml);
    case (ml)
      MEM_LEN_B: nbytes = 1;
      MEM_LEN_H: nbytes = 2;
      default:   nbytes = 4;
    endcase
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = {v[23:0], mem[a + 32'(i)]};
    return v;
  endfunction

  task automatic wr_mem(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) mem[a + 32'(i)] = d[8*(n-1-i) +: 8];
  endtask

  task automatic push(input mem_access_t k, input logic [31:0] a, input mem_len_t ml, input logic [31:0] d);
    beat_t b;
    b.kind = k; b.addr = a; b.ml = ml; b.data = d;
    sbq.push_back(b);
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(posedge clk); #1;
    srcAddr = s; dstAddr = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // First negedge seen here is cycle 1 after the start cycle.
  task automatic wait_done(output int c, output int b);
    c = 0; b = 0;
    do begin
      @(negedge clk);
      c++;
      if (busy) b++;
    end while (!done && c < 200);
    check("done seen", {31'h0, done}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, {31'h0, busy}, 32'h0);
    check({tag, " done"}, {31'h0, done}, 32'h0);
    check({tag, " accessType"}, 32'(db.accessType), 32'(MEM_ACCESS_NONE));
    check({tag, " addr"}, db.addr, 32'h0);
    check({tag, " dataOut"}, db.dataOut, 32'h0);
    check({tag, " memLen"}, 32'(db.memLen), 32'(MEM_LEN_W));
  endtask

  // Ready driver: held high unless toggling is enabled.
  initial begin
    db.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      db.ready = toggle_en ? ~db.ready : 1'b1;
    end
  end

  // Responder: data is registered on the accept edge.
  initial begin
    mem_access_t p_kind;
    logic [31:0] p_addr, p_data;
    mem_len_t    p_ml;
    logic        pend;
    db.dataIn = 32'h0;
    forever begin
      @(negedge clk);
      pend   = (db.accessType != MEM_ACCESS_NONE) && db.ready && !res;
      p_kind = db.accessType; p_addr = db.addr; p_ml = db.memLen; p_data = db.dataOut;
      @(posedge clk); #1;
      if (pend) begin
        if (p_kind == MEM_ACCESS_W) wr_mem(p_addr, p_data, nbytes(p_ml));
        else db.dataIn = rd_mem(p_addr, nbytes(p_ml));
      end
    end
  end

  // Monitor: pops one expected beat per accepted request; checks stall stability.
  initial begin
    beat_t       e;
    logic        prev_stall = 1'b0;
    mem_access_t prev_kind  = MEM_ACCESS_NONE;
    logic [31:0] prev_addr  = 32'h0;
    logic [31:0] prev_dout  = 32'h0;
    mem_len_t    prev_ml    = MEM_LEN_W;
    forever begin
      @(negedge clk);
      if (prev_stall && !res) begin
        check("stall accessType", 32'(db.accessType), 32'(prev_kind));
        check("stall addr", db.addr, prev_addr);
        check("stall memLen", 32'(db.memLen), 32'(prev_ml));
        check("stall dataOut", db.dataOut, prev_dout);
      end
      if (db.accessType != MEM_ACCESS_NONE && db.ready && !res) begin
        if (sbq.size() == 0) begin
          check("unexpected beat", 32'(sbq.size()), 32'h1);
        end else begin
          e = sbq.pop_front();
          check("beat kind", 32'(db.accessType), 32'(e.kind));
          check("beat addr", db.addr, e.addr);
          check("beat memLen", 32'(db.memLen), 32'(e.ml));
          if (e.kind == MEM_ACCESS_W) check("beat wdata", db.dataOut, e.data);
        end
      end
      prev_stall = (db.accessType != MEM_ACCESS_NONE) && !db.ready && !res;
      prev_kind  = db.accessType;
      prev_addr  = db.addr;
      prev_ml    = db.memLen;
      prev_dout  = db.dataOut;
    end
  end

  initial begin
    res = 1'b1; start = 1'b0; srcAddr = 32'h0; dstAddr = 32'h0; len = 16'h0;
    toggle_en = 1'b0;
`ifdef DMA_FILL_EN
    fillMode = 1'b0; fillData = 32'h0;
`endif
    for (int i = 0; i < 12; i++) mem[32'h100 + 32'(i)] = 8'(i + 1);
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    res = 1'b0;

    // Word copy with ready high.
    push(MEM_ACCESS_R, 32'h100, MEM_LEN_W, 32'h0);
    push(MEM_ACCESS_W, 32'h200, MEM_LEN_W, 32'h01020304);
    push(MEM_ACCESS_R, 32'h104, MEM_LEN_W, 32'h0);
    push(MEM_ACCESS_W, 32'h204, MEM_LEN_W, 32'h05060708);
    start_copy(32'h100, 32'h200, 16'd8);
    wait_done(cyc, bc);
    check("word done cycle", cyc, 32'd7);
    check("word busy cycles", bc, 32'd6);
    @(negedge clk);
    check("word done pulse", {31'h0, done}, 32'h0);
    check("word mem 200", rd_mem(32'h200, 4), 32'h01020304);
    check("word mem 204", rd_mem(32'h204, 4), 32'h05060708);
    check("word queue empty", 32'(sbq.size()), 32'h0);

    // Mixed tail: word, half, byte.
    mem[32'h307] = 8'hAA;
    push(MEM_ACCESS_R, 32'h100, MEM_LEN_W, 32'h0);
    push(MEM_ACCESS_W, 32'h300, MEM_LEN_W, 32'h01020304);
    push(MEM_ACCESS_R, 32'h104, MEM_LEN_H, 32'h0);
    push(MEM_ACCESS_W, 32'h304, MEM_LEN_H, 32'h00000506);
    push(MEM_ACCESS_R, 32'h106, MEM_LEN_B, 32'h0);
    push(MEM_ACCESS_W, 32'h306, MEM_LEN_B, 32'h00000007);
    start_copy(32'h100, 32'h300, 16'd7);
    wait_done(cyc, bc);
    check("tail done cycle", cyc, 32'd10);
    check("tail mem 300", rd_mem(32'h300, 4), 32'h01020304);
    check("tail mem 304", rd_mem(32'h304, 4), 32'h050607AA);
    check("tail queue empty", 32'(sbq.size()), 32'h0);

    // Ready toggling every cycle.
    push(MEM_ACCESS_R, 32'h100, MEM_LEN_W, 32'h0);
    push(MEM_ACCESS_W, 32'h500, MEM_LEN_W, 32'h01020304);
    toggle_en = 1'b1;
    start_copy(32'h100, 32'h500, 16'd4);
    wait_done(cyc, bc);
    toggle_en = 1'b0;
    check("stall mem 500", rd_mem(32'h500, 4), 32'h01020304);
    check("stall queue empty", 32'(sbq.size()), 32'h0);
    repeat (2) @(posedge clk);

    // len=0, plus a start landing on the DONE cycle.
    start_copy(32'h100, 32'h900, 16'd0);
    @(negedge clk);
    check("len0 done cycle1", {31'h0, done}, 32'h1);
    check("len0 busy", {31'h0, busy}, 32'h0);
    srcAddr = 32'h100; dstAddr = 32'h900; len = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0 done once", {31'h0, done}, 32'h0);
    idle_busy = 0;
    repeat (6) begin @(negedge clk); if (busy) idle_busy++; end
    check("start at done ignored", idle_busy, 32'd0);
    check("len0 queue empty", 32'(sbq.size()), 32'h0);

    // Second start while busy is ignored.
    wr_mem(32'h700, 32'h11111111, 4);
    push(MEM_ACCESS_R, 32'h100, MEM_LEN_W, 32'h0);
    push(MEM_ACCESS_W, 32'h600, MEM_LEN_W, 32'h01020304);
    start_copy(32'h100, 32'h600, 16'd4);
    @(posedge clk); #1;
    srcAddr = 32'h104; dstAddr = 32'h700; len = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, bc);
    idle_busy = 0;
    repeat (6) begin @(negedge clk); if (busy) idle_busy++; end
    check("busy start no restart", idle_busy, 32'd0);
    check("busy start mem 600", rd_mem(32'h600, 4), 32'h01020304);
    check("busy start mem 700", rd_mem(32'h700, 4), 32'h11111111);
    check("busy start queue empty", 32'(sbq.size()), 32'h0);

    // Reset during the second write beat of a 12-byte copy.
    wr_mem(32'h804, 32'h55555555, 4);
    push(MEM_ACCESS_R, 32'h100, MEM_LEN_W, 32'h0);
    push(MEM_ACCESS_W, 32'h800, MEM_LEN_W, 32'h01020304);
    push(MEM_ACCESS_R, 32'h104, MEM_LEN_W, 32'h0);
    start_copy(32'h100, 32'h800, 16'd12);
    repeat (5) @(posedge clk); #1;
    check("pre-reset accessType", 32'(db.accessType), 32'(MEM_ACCESS_W));
    check("pre-reset addr", db.addr, 32'h804);
    res = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    res = 1'b0;
    repeat (3) @(posedge clk);
    check("midreset mem 800", rd_mem(32'h800, 4), 32'h01020304);
    check("midreset mem 804", rd_mem(32'h804, 4), 32'h55555555);
    check("midreset queue empty", 32'(sbq.size()), 32'h0);

    // Destination wraps past 0xFFFFFFFF.
    push(MEM_ACCESS_R, 32'h100, MEM_LEN_W, 32'h0);
    push(MEM_ACCESS_W, 32'hFFFFFFFC, MEM_LEN_W, 32'h01020304);
    push(MEM_ACCESS_R, 32'h104, MEM_LEN_W, 32'h0);
    push(MEM_ACCESS_W, 32'h00000000, MEM_LEN_W, 32'h05060708);
    start_copy(32'h100, 32'hFFFFFFFC, 16'd8);
    wait_done(cyc, bc);
    check("wrap done cycle", cyc, 32'd7);
    check("wrap mem top", rd_mem(32'hFFFFFFFC, 4), 32'h01020304);
    check("wrap mem 0", rd_mem(32'h0, 4), 32'h05060708);
    check("wrap queue empty", 32'(sbq.size()), 32'h0);

`ifdef DMA_FILL_EN
    // Pattern fill: write-only beats.
    push(MEM_ACCESS_W, 32'h400, MEM_LEN_W, 32'hDEADBEEF);
    push(MEM_ACCESS_W, 32'h404, MEM_LEN_H, 32'h0000BEEF);
    fillMode = 1'b1; fillData = 32'hDEADBEEF;
    start_copy(32'h100, 32'h400, 16'd6);
    fillMode = 1'b0;
    wait_done(cyc, bc);
    check("fill done cycle", cyc, 32'd3);
    check("fill mem 400", rd_mem(32'h400, 4), 32'hDEADBEEF);
    check("fill mem 404", rd_mem(32'h404, 2), 32'h0000BEEF);
    check("fill queue empty", 32'(sbq.size()), 32'h0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Bus initiator on the shared DataBus. It is the master-side counterpart to the memory and peripheral responders.
- On a start pulse it copies a byte-length region from a source address to a destination address. It uses read/write DataBus transactions in big-endian order: the byte at the lowest address is the MSB.
- It sits beside CPUCore behind the bus arbiter. Its bus pins use the same signal set as CPUCore's.

Parameters:
- LEN_W, 16, width of the byte-length input and the remaining-bytes counter.
- WORD_ONLY, 0, when 1 every beat is a word access (len must be a multiple of 4; low 2 bits of len are ignored).

Ports:
- clk  input  1  system clock, rising edge
- res  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; sampled only in IDLE
- srcAddr  input  32  source byte address, latched at start
- dstAddr  input  32  destination byte address, latched at start
- len  input  LEN_W  byte count, latched at start
- busy  output  1  high from the cycle after an accepted start until DONE
- done  output  1  one-cycle pulse at completion
- db_addr  output  32  bus address
- db_dataOut  output  32  write data, right-aligned (byte in [7:0], half in [15:0])
- db_accessType  output  `MEM_ACCESS_T  access kind (`MEM_ACCESS_NONE/R/W; never X)
- db_memLen  output  `MEM_LEN  `MEM_LEN_B/H/W
- db_dataIn  input  32  read data from responder, right-aligned
- db_ready  input  1  responder ready; a request is accepted on a rising edge with db_ready=1

Behaviour:
- Reset (async, res=1): state=IDLE, busy=0, done=0, db_accessType=`MEM_ACCESS_NONE, db_addr=0, db_dataOut=0, db_memLen=`MEM_LEN_W, all internal counters 0. Reset mid-transfer abandons the copy immediately; no further bus beats are issued.
- States: IDLE, RD, RDATA, WR, DONE.
- IDLE:
  - On start=1, latch src, dst and rem=len, then go to RD.
  - If len=0, go straight to DONE with no bus beat.
- RD:
  - Drive accessType=R, db_addr=src, and memLen chosen from rem: W if rem>=4, else H if rem>=2, else B.
  - Hold all bus outputs stable while db_ready=0.
  - On the accept edge, go to RDATA.
- RDATA:
  - Bus outputs NONE.
  - db_dataIn is valid this cycle (responder registers data on the accept edge). Capture it at the end of the cycle, then go to WR.
- WR:
  - Drive accessType=W, db_addr=dst, the same memLen, and db_dataOut=captured data.
  - Hold while db_ready=0.
  - On the accept edge, step=4/2/1: src+=step, dst+=step, rem-=step.
  - Then go to RD if rem (after decrement) is nonzero, else DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- busy: high in RD, RDATA and WR.
- Timing: minimum 3 cycles per beat with db_ready tied high. Total cycles = 3 × beats + 1 (DONE).
- Arithmetic: addresses wrap modulo 2^32 (0xFFFFFFFC+4 -> 0). rem never underflows, because the step selection guarantees step<=rem.
- Alignment: none enforced. Addresses are passed through unchanged; the responder defines unaligned behaviour.
- start while busy: ignored, with no latch and no effect on the current copy.
- start coincident with the DONE cycle: ignored.

Optional Feature:
- Macro: DMA_FILL_EN.
- With the macro defined:
  - Extra input fillMode (1 bit) and input fillData (32 bits) are added, both latched at start.
  - When fillMode=1, states RD and RDATA are skipped; WR drives fillData, right-aligned and truncated to the access length.
  - Beat cost is 1 cycle plus ready stalls.
- Without the macro: neither port exists and all beats are read-then-write.

Decomposition:
- DataBus.vh (existing) supplies `MEM_ACCESS_T, `MEM_LEN and their value macros; it is not modified.
- New dma.vh holds the state encodings (3-bit DMA_ST_IDLE/RD/RDATA/WR/DONE) and the step constants.
- One sub-module, dma_len_sel: combinational; rem -> {memLen, step}; honours WORD_ONLY.

Test Plan:
- Word copy, ready high: src=0x100, dst=0x200, len=8; memory 0x100..0x107 = 01..08.
  - 0x200..0x207 = 01..08.
  - Beats W,W; done pulses at cycle 7 after start; busy high for cycles 1–6.
- Mixed tail: len=7 from 0x100 -> 0x300. Sequence: R/W word, R/W half, R/W byte; 0x300..0x306 match the source and 0x307 is untouched.
- Ready stall: toggle db_ready 0/1 every cycle during len=4.
  - db_addr, memLen and dataOut stay stable while ready=0.
  - Exactly one R and one W accepted; data correct.
- Edge cases:
  - len=0 -> done one cycle after start, no bus activity.
  - A second start during busy is ignored.
  - dst=0xFFFFFFFC, len=8 -> second write at address 0x0.
- Reset mid-copy: assert res during WR of beat 2 of len=12.
  - Outputs go to their reset values in the same cycle; only beat 1 is written; a later start works normally.
- DMA_FILL_EN: fillMode=1, fillData=0xDEADBEEF, len=6, dst=0x400.
  - Bytes at 0x400..0x405 = DE AD BE EF BE EF (word write 0xDEADBEEF, then half write 0xBEEF).
  - No R beats.
